// File: rtl/clk_period_monitor_if.sv
// Bundles the monitored slow clock and the measurement/status outputs of clk_period_monitor.
interface clk_period_monitor_if #(
  parameter int CNT_W = 26
);
  logic             slow_clk_in;
  logic             edge_stb;
  logic [CNT_W-1:0] half_period;
  logic             in_range;
  logic             locked;
  logic             lost;

  modport master (
    output slow_clk_in,
    input  edge_stb, half_period, in_range, locked, lost
  );

  modport slave (
    input  slow_clk_in,
    output edge_stb, half_period, in_range, locked, lost
  );
endinterface

// File: rtl/clk_period_monitor.sv
// Measures each half-period of an asynchronous slow clock in clk_in cycles and reports lock/loss.
// Latency: edge_stb and results 3 clk_in after a slow-clock change; free-running, no backpressure.
module clk_period_monitor #(
  parameter int CNT_W    = 26,
  parameter int EXP_HALF = 5001,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 20000
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  clk_period_monitor_if.slave  mon
);

  localparam int               LO_INT  = (EXP_HALF > TOL) ? EXP_HALF - TOL : 0;
  localparam logic [CNT_W-1:0] LO      = CNT_W'(LO_INT);
  localparam logic [CNT_W-1:0] HI      = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               GW      = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0]    GOOD_TGT = GW'(LOCK_CNT);

  typedef enum logic [1:0] {ACQUIRE, MEASURE, LOCKED, LOST} state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic             slow_edge;
  logic [CNT_W-1:0] cnt;
  logic [GW-1:0]    good, good_nxt, good_inc;
  logic             meas_ok, timeout, measure;
  logic             edge_stb_q, in_range_q, locked_q, lost_q;
  logic [CNT_W-1:0] half_q;

  assign slow_edge = s2 ^ s3;
  assign meas_ok   = (cnt >= LO) && (cnt <= HI);
  assign timeout   = (cnt == TMO);
  assign good_inc  = good + 1'b1;

  // Timeout wins over a coincident edge; ACQUIRE/LOST edges only restart measurement.
  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    measure   = 1'b0;
    if (timeout && state != LOST) begin
      state_nxt = LOST;
      good_nxt  = '0;
    end else if (slow_edge) begin
      case (state)
        ACQUIRE, LOST: begin
          state_nxt = MEASURE;
          good_nxt  = '0;
        end
        MEASURE: begin
          measure = 1'b1;
          if (meas_ok) begin
            good_nxt = good_inc;
            if (good_inc >= GOOD_TGT) state_nxt = LOCKED;
          end else begin
            good_nxt = '0;
          end
        end
        LOCKED: begin
          measure = 1'b1;
          if (!meas_ok) begin
            state_nxt = MEASURE;
            good_nxt  = '0;
          end
        end
        default: state_nxt = ACQUIRE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      cnt        <= '0;
      good       <= '0;
      state      <= ACQUIRE;
      edge_stb_q <= 1'b0;
      half_q     <= '0;
      in_range_q <= 1'b0;
      locked_q   <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      s1         <= mon.slow_clk_in;
      s2         <= s1;
      s3         <= s2;
      // The edge cycle itself is cycle 1 of the new half-period.
      if (slow_edge)            cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX)  cnt <= cnt + 1'b1;
      good       <= good_nxt;
      state      <= state_nxt;
      edge_stb_q <= slow_edge;
      if (measure) begin
        half_q     <= cnt;
        in_range_q <= meas_ok;
      end
      locked_q   <= (state_nxt == LOCKED);
      lost_q     <= (state_nxt == LOST);
    end
  end

  assign mon.edge_stb    = edge_stb_q;
  assign mon.half_period = half_q;
  assign mon.in_range    = in_range_q;
  assign mon.locked      = locked_q;
  assign mon.lost        = lost_q;

endmodule
